rv32i_lsu: RTL
==============

# rv32i_lsu

Load/store unit for the RV32I pipeline, on the consumer side of the EX stage's memory-address output. Accepts one memory operation per handshake: the effective address computed in EX, rs2 store data, and size/sign controls. Drives a request/grant/response data-memory port with byte lanes, then returns sign- or zero-extended load data to writeback. Holds the pipeline via `ex_ready` while a transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in REQ+WAIT before abort (only used with the timeout feature).

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX presents a memory op
- `ex_ready`  out  1  LSU idle, can accept
- `ex_addr`  in  32  effective address from EX
- `ex_wdata`  in  32  rs2 value for stores
- `ex_load`, `ex_store`  in  1 each  operation kind
- `ex_size`  in  2  00 byte, 01 half, 10/11 word
- `ex_unsigned`  in  1  zero-extend load (LBU/LHU)
- `ex_rd`  in  5  load destination register
- `mem_req`  out  1  request to data memory
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read data
- `wb_valid`  out  1  one-cycle load result pulse
- `wb_rd`  out  5  destination register
- `wb_data`  out  32  extended load data
- `misalign`  out  1  one-cycle misaligned-access pulse
- `misalign_addr`  out  32  offending address, held until next misalign
- `bus_err`  out  1  one-cycle timeout pulse

## Operation
- FSM: IDLE, REQ, WAIT, RESP. `ex_ready` = (state==IDLE).
- IDLE: on `ex_valid & ex_ready`, latch all ex_* inputs.
  - Neither or both of load/store: no-op, stay IDLE, no outputs.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0): `misalign`=1 next cycle, `misalign_addr`=addr, stay IDLE, no memory access.
  - Otherwise go to REQ.
- REQ: `mem_req`=1 with stable `mem_we/addr/be/wdata` until `mem_gnt`=1 sampled. Store then goes to IDLE; load goes to WAIT.
- WAIT: on `mem_rvalid`, capture extended data and go to RESP.
- RESP: `wb_valid`=1 for one cycle; then IDLE.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111`. Loads drive the same mask.
- Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word as-is.
- Load extract: byte lane `rdata[8*addr[1:0]+:8]`, half lane `rdata[16*addr[1]+:16]`, sign-extended unless `ex_unsigned`; word unchanged.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset: state IDLE; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_rd`, `wb_data`, `misalign`, `misalign_addr`, `bus_err` all 0; `ex_ready`=1 once `rst_n` deasserts.
- Reset mid-transaction: immediate abort to IDLE, `mem_req` drops asynchronously, no writeback.
- All memory-side and wb outputs are registered.
- Accept at T → `mem_req` high at T+1.
- Store with zero-wait grant: gnt at T+1, `ex_ready` high at T+2.
- Load: earliest `mem_rvalid` is the cycle after gnt. Zero-wait load: gnt T+1, rvalid T+2, `wb_valid` T+3, `ex_ready` T+4.
- Misaligned op: `misalign` at T+1, `ex_ready` stays 1.

## Configuration
- `RV32I_LSU_TIMEOUT_EN` defined: a counter clears on entering REQ and counts each cycle in REQ or WAIT. When it reaches `TIMEOUT_CYCLES`:
  - `bus_err` pulses one cycle;
  - `mem_req` drops;
  - FSM returns to IDLE with no writeback.
- Not defined: waits indefinitely; `bus_err` is tied 0; no counter logic.

## Test plan
- SB to addr 0x1003, rs2=0x000000A5, gnt at once → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x1000, `ex_ready` high 2 cycles after accept.
- LB addr 0x2002, rdata=0x0080FF00 → `wb_data`=0xFFFFFF80. Same with LBU → 0x00000080. `wb_rd` matches; `wb_valid` at T+3.
- LH addr 0x3001 → `misalign`=1 at T+1, `misalign_addr`=0x3001, `mem_req` never rises.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt → `mem_req` and address held stable throughout; `ex_ready` low until after the `wb_valid` pulse; exactly one wb pulse.
- With `RV32I_LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, gnt never asserted → `bus_err` pulse, `mem_req` low, no `wb_valid`, FSM back in IDLE.
- `rst_n` low during WAIT → all outputs 0; a later stray `mem_rvalid` produces no writeback.

Source files
------------

// File: rtl/rv32i_lsu_if.sv
// Data-memory request/grant/response port: the LSU drives it as master, the memory answers as slave.
interface rv32i_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one memory op per EX handshake, byte-lane memory port, extended load writeback.
// Optional bus timeout (abort with bus_err after TIMEOUT_CYCLES) is enabled by defining RV32I_LSU_TIMEOUT_EN.
module rv32i_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [31:0]        ex_addr,
  input  logic [31:0]        ex_wdata,
  input  logic               ex_load,
  input  logic               ex_store,
  input  logic [1:0]         ex_size,
  input  logic               ex_unsigned,
  input  logic [4:0]         ex_rd,
  rv32i_lsu_if.master        mem,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               misalign,
  output logic [31:0]        misalign_addr,
  output logic               bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        is_mem_op;
  logic        misaligned;
  logic        start;
  logic        flag_mis;
  logic        timeout;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        load_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign ex_ready   = (state == IDLE);
  assign is_mem_op  = ex_valid && ex_ready && (ex_load ^ ex_store);
  assign misaligned = (ex_size == 2'b01) ? ex_addr[0]
                                         : (ex_size[1] && (ex_addr[1:0] != 2'b00));
  assign start      = is_mem_op && !misaligned;
  assign flag_mis   = is_mem_op && misaligned;

  // Byte enables and lane-replicated store data for the op being accepted.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = ex_wdata;
    case (ex_size)
      2'b00: begin
        be_new    = 4'b0001 << ex_addr[1:0];
        wdata_new = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << ex_addr[1:0];
        wdata_new = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_lane = mem.mem_rdata[7:0];
    case (off_q)
      2'd1:    byte_lane = mem.mem_rdata[15:8];
      2'd2:    byte_lane = mem.mem_rdata[23:16];
      2'd3:    byte_lane = mem.mem_rdata[31:24];
      default: byte_lane = mem.mem_rdata[7:0];
    endcase
    half_lane = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
      2'b01:   load_ext = {{16{half_lane[15] & ~uns_q}}, half_lane};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Grant and read-valid win over a timeout landing in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = REQ;
      REQ: begin
        if (mem.mem_gnt)  state_next = load_q ? WAIT : IDLE;
        else if (timeout) state_next = IDLE;
      end
      WAIT: begin
        if (mem.mem_rvalid) state_next = RESP;
        else if (timeout)   state_next = IDLE;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      load_q        <= 1'b0;
      rd_q          <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (start) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= ex_store;
        mem.mem_addr  <= {ex_addr[31:2], 2'b00};
        mem.mem_be    <= be_new;
        mem.mem_wdata <= wdata_new;
        off_q         <= ex_addr[1:0];
        size_q        <= ex_size;
        uns_q         <= ex_unsigned;
        load_q        <= ex_load;
        rd_q          <= ex_rd;
      end
      if (flag_mis) begin
        misalign      <= 1'b1;
        misalign_addr <= ex_addr;
      end
      if ((state == REQ) && (mem.mem_gnt || timeout)) mem.mem_req <= 1'b0;
      if ((state == WAIT) && mem.mem_rvalid) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= load_ext;
      end
    end
  end

`ifdef RV32I_LSU_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  assign timeout = ((state == REQ) || (state == WAIT)) && (tmo_cnt >= TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (start)                                tmo_cnt <= '0;
      else if ((state == REQ) || (state == WAIT)) tmo_cnt <= tmo_cnt + 32'd1;
      if (timeout && (((state == REQ) && !mem.mem_gnt) || ((state == WAIT) && !mem.mem_rvalid)))
        bus_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign bus_err    = 1'b0;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule
